// File: rtl/fb_pkg.sv
// Frame buffer controller package.
// Holds the default frame geometry / data widths and the controller state
// encoding shared by framebuf_ctrl and its read-port sub-module.
package fb_pkg;

    localparam int unsigned FB_ADDR_W       = 17;
    localparam int unsigned FB_DATA_W       = 24;
    localparam int unsigned FB_FRAME_PIXELS = 76800;   // 320x240

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_VSYNC = 2'd1;
    localparam logic [1:0] ST_CAPTURE    = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

endpackage

// File: rtl/fb_rd_port.sv
// CPU read pipeline for the shared frame buffer RAM port.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   cpu_rd_addr_i     - CPU read address (stable while the request is held)
//   grant_i           - arbiter grants a read this cycle
//   ram_rdata_i       - RAM read data, valid one cycle after the read is on the port
//   rd_busy_o         - a granted read is still in flight
//   ram_issue_o       - grant that actually needs a RAM access (address in range)
//   cpu_rd_data_o     - read data, held after the valid pulse
//   cpu_rd_valid_o    - one-cycle valid pulse, two cycles after the grant
module fb_rd_port
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W       = FB_ADDR_W,
    parameter int unsigned DATA_W       = FB_DATA_W,
    parameter int unsigned FRAME_PIXELS = FB_FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_rd_addr_i,
    input  logic              grant_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              rd_busy_o,
    output logic              ram_issue_o,
    output logic [DATA_W-1:0] cpu_rd_data_o,
    output logic              cpu_rd_valid_o
);

    localparam logic [ADDR_W:0] FP_LIMIT = (ADDR_W+1)'(FRAME_PIXELS);

    logic              addr_oor;
    logic              s1_q, s1_oor_q;
    logic              s2_q, s2_oor_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rd_now;

    assign addr_oor    = ({1'b0, cpu_rd_addr_i} >= FP_LIMIT);
    assign ram_issue_o = grant_i & ~addr_oor;

    // Out-of-range reads still walk the pipeline so the valid pulse keeps
    // the same latency; they simply return zero instead of RAM data.
    assign rd_now = s2_oor_q ? '0 : ram_rdata_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= 1'b0;
            s1_oor_q <= 1'b0;
            s2_q     <= 1'b0;
            s2_oor_q <= 1'b0;
            data_q   <= '0;
        end else begin
            s1_q     <= grant_i;
            s1_oor_q <= grant_i & addr_oor;
            s2_q     <= s1_q;
            s2_oor_q <= s1_oor_q;
            if (s2_q) begin
                data_q <= rd_now;
            end
        end
    end

    // Busy through the valid cycle, so a still-held request re-issues only
    // one cycle after the CPU has seen valid.
    assign rd_busy_o      = s1_q | s2_q;
    assign cpu_rd_valid_o = s2_q;
    assign cpu_rd_data_o  = s2_q ? rd_now : data_q;

endmodule

// File: rtl/framebuf_ctrl.sv
// Frame buffer controller: captures one camera frame into the single-port
// frame RAM and arbitrates CPU reads onto the same port (writes win).
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   start, abort              - one-cycle command pulses (abort wins)
//   vsync, pixel_valid/_data  - capture stream
//   cpu_rd_req/_addr          - CPU read request (level, held until valid)
//   cpu_rd_data/_valid        - CPU read response
//   ram_en/_rw/_addr/_wdata   - registered RAM port, ram_rdata returned
//   busy, frame_done, short_frame, pix_count - status
module framebuf_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W       = FB_ADDR_W,
    parameter int unsigned DATA_W       = FB_DATA_W,
    parameter int unsigned FRAME_PIXELS = FB_FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              vsync,
    input  logic              pixel_valid,
    input  logic [DATA_W-1:0] pixel_data,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_rd_valid,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              frame_done,
    output logic              short_frame,
    output logic [ADDR_W-1:0] pix_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              done_q, done_d;
    logic              short_q, short_d;
    logic              vsync_d_q;
    logic              vsync_rise;
    logic              pix_wr;

    logic              ram_en_q, ram_rw_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    logic              rd_busy, rd_grant, rd_issue;

    assign vsync_rise = vsync & ~vsync_d_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        done_d   = done_q;
        short_d  = short_q;
        pix_wr   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            short_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d  = ST_WAIT_VSYNC;
                        wr_ptr_d = '0;
                        done_d   = 1'b0;
                        short_d  = 1'b0;
                    end
                end
                ST_WAIT_VSYNC: begin
                    if (vsync_rise) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // A pixel coinciding with the terminating vsync is dropped.
                    if (vsync_rise) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        short_d = 1'b1;
                    end else if (pixel_valid) begin
                        pix_wr   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_ptr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            short_d = 1'b0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
            vsync_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            done_q    <= done_d;
            short_q   <= short_d;
            vsync_d_q <= vsync;
        end
    end

    // Pixel writes own the port whenever one is issued this cycle.
    assign rd_grant = cpu_rd_req & ~rd_busy & ~pix_wr;

    fb_rd_port #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) u_rd_port (
        .clk            (clk),
        .rst            (rst),
        .cpu_rd_addr_i  (cpu_rd_addr),
        .grant_i        (rd_grant),
        .ram_rdata_i    (ram_rdata),
        .rd_busy_o      (rd_busy),
        .ram_issue_o    (rd_issue),
        .cpu_rd_data_o  (cpu_rd_data),
        .cpu_rd_valid_o (cpu_rd_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_en_q    <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else if (pix_wr) begin
            ram_en_q    <= 1'b1;
            ram_rw_q    <= 1'b1;
            ram_addr_q  <= wr_ptr_q;
            ram_wdata_q <= pixel_data;
        end else if (rd_issue) begin
            ram_en_q    <= 1'b1;
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= cpu_rd_addr;
        end else begin
            ram_en_q    <= 1'b0;
        end
    end

    assign ram_en      = ram_en_q;
    assign ram_rw      = ram_rw_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign busy        = (state_q == ST_WAIT_VSYNC) || (state_q == ST_CAPTURE);
    assign frame_done  = done_q;
    assign short_frame = short_q;
    assign pix_count   = wr_ptr_q;

endmodule
